// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution filter: FSM states,
// tap count and accumulator width helper.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_STREAM,
        S_FLUSH
    } state_t;

    localparam int NUM_TAPS = 9;

    // Headroom for nine signed products of pixel x coefficient.
    function automatic int acc_width(input int data_w, input int coeff_w);
        return data_w + coeff_w + 5;
    endfunction

endpackage

// File: rtl/conv_filter_param_module_if.sv
// Bus bundle of the convolution filter: coefficient/pixel write
// strobes and data in, filtered pixel, valid pulse and status out.
// master = producer/consumer side, slave = filter side.
interface conv_filter_param_module_if #(
    parameter int DATA_W  = 8,
    parameter int COEFF_W = 8
);
    logic                      coeff_load;
    logic signed [COEFF_W-1:0] coeff_in;
    logic                      data_load;
    logic [DATA_W-1:0]         data_i;
    logic                      border_mode;
    logic [DATA_W-1:0]         data_o;
    logic                      data_write;
    logic                      coeff_ready;
    logic                      busy;

    modport master (
        output coeff_load, coeff_in, data_load, data_i, border_mode,
        input  data_o, data_write, coeff_ready, busy
    );

    modport slave (
        input  coeff_load, coeff_in, data_load, data_i, border_mode,
        output data_o, data_write, coeff_ready, busy
    );
endinterface

// File: rtl/conv_line_buffer_module.sv
// One-line delay: circular buffer of IMG_W words advanced per beat.
// Ports: clk, rst (sync, active-high), en (beat), din, dout (din of IMG_W beats ago).
module conv_line_buffer_module #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int PTR_W = $clog2(IMG_W);

    logic [DATA_W-1:0] mem [IMG_W];
    logic [PTR_W-1:0]  ptr;

    // Read-before-write at the same slot gives exactly IMG_W beats of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[ptr] <= din;
            ptr      <= (ptr == PTR_W'(IMG_W - 1)) ? '0 : ptr + 1'b1;
        end
    end
endmodule

// File: rtl/conv_filter_param_module.sv
// 3x3 streaming convolution with programmable signed kernel, border handling,
// 3-stage datapath (products, adder tree, shift/saturate).
// Ports: clk, rst (sync, active-high), bus (slave side of the filter bundle).
module conv_filter_param_module
    import conv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COEFF_W = 8,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int SHIFT   = 0
) (
    input logic clk,
    input logic rst,
    conv_filter_param_module_if.slave bus
);
    localparam int ACC_W  = acc_width(DATA_W, COEFF_W);
    localparam int PIX_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + 1 + COEFF_W;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int FL_W   = $clog2(IMG_W + 1);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int BEAT_W = $clog2(NPIX + IMG_W + 2);
    localparam int IDX_W  = 4;

    state_t state, state_nxt;

    logic [IDX_W-1:0]          idx;
    logic signed [COEFF_W-1:0] coeff [NUM_TAPS];
    logic [COL_W-1:0]          col, c_col;
    logic [ROW_W-1:0]          row, c_row;
    logic [FL_W-1:0]           flush_cnt;
    logic [BEAT_W-1:0]         beat_cnt;

    logic coeff_wr, pix_acc, flush_beat, beat;
    logic last_pix, flush_done, launch, border_c;
    logic busy_s, ready_s;

    assign coeff_wr   = bus.coeff_load
                      && (state inside {S_IDLE, S_LOAD, S_READY});
    assign pix_acc    = bus.data_load && !coeff_wr
                      && (state inside {S_READY, S_STREAM});
    assign flush_beat = (state == S_FLUSH);
    assign beat       = pix_acc || flush_beat;
    assign last_pix   = pix_acc && (row == ROW_W'(IMG_H - 1))
                      && (col == COL_W'(IMG_W - 1));
    assign flush_done = flush_beat && (flush_cnt == FL_W'(IMG_W));
    // The window centre trails the newest pixel by one line plus one.
    assign launch     = beat && (beat_cnt >= BEAT_W'(IMG_W + 1));
    assign border_c   = (c_row == '0) || (c_row == ROW_W'(IMG_H - 1))
                      || (c_col == '0) || (c_col == COL_W'(IMG_W - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_LOAD, S_READY: begin
                if (coeff_wr) begin
                    state_nxt = (idx == IDX_W'(NUM_TAPS - 1)) ? S_READY : S_LOAD;
                end else if (pix_acc) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: if (last_pix)   state_nxt = S_FLUSH;
            S_FLUSH:  if (flush_done) state_nxt = S_READY;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_s  = (state == S_FLUSH);
        ready_s = state inside {S_READY, S_STREAM, S_FLUSH};
    end

    assign bus.busy        = busy_s;
    assign bus.coeff_ready = ready_s;

    // ---------------- counters and coefficients ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            col       <= '0;
            row       <= '0;
            c_col     <= '0;
            c_row     <= '0;
            flush_cnt <= '0;
            beat_cnt  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) coeff[i] <= '0;
        end else begin
            if (coeff_wr) begin
                coeff[idx] <= bus.coeff_in;
                idx <= (idx == IDX_W'(NUM_TAPS - 1)) ? '0 : idx + 1'b1;
            end
            if (beat) beat_cnt <= beat_cnt + 1'b1;
            if (pix_acc) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (flush_beat) flush_cnt <= flush_cnt + 1'b1;
            if (launch) begin
                if (c_col == COL_W'(IMG_W - 1)) begin
                    c_col <= '0;
                    c_row <= (c_row == ROW_W'(IMG_H - 1)) ? '0 : c_row + 1'b1;
                end else begin
                    c_col <= c_col + 1'b1;
                end
            end
            if (flush_done) begin
                col       <= '0;
                row       <= '0;
                c_col     <= '0;
                c_row     <= '0;
                flush_cnt <= '0;
                beat_cnt  <= '0;
            end
        end
    end

    // ---------------- window ----------------
    // Each word carries the pixel plus the border_mode bit sampled with it.
    logic [PIX_W-1:0] pix_in, lb1_q, lb2_q;
    logic [PIX_W-1:0] win     [3][3];
    logic [PIX_W-1:0] win_nxt [3][3];

    assign pix_in = flush_beat ? '0 : {bus.border_mode, bus.data_i};

    conv_line_buffer_module #(.DATA_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
        .clk(clk), .rst(rst), .en(beat), .din(pix_in), .dout(lb1_q)
    );

    conv_line_buffer_module #(.DATA_W(PIX_W), .IMG_W(IMG_W)) u_lb2 (
        .clk(clk), .rst(rst), .en(beat), .din(lb1_q), .dout(lb2_q)
    );

    // Row 0 = oldest line (top), column 0 = oldest pixel (left).
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        win_nxt[0][2] = lb2_q;
        win_nxt[1][2] = lb1_q;
        win_nxt[2][2] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win[r][c] <= '0;
        end else if (beat) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win[r][c] <= win_nxt[r][c];
        end
    end

    // ---------------- stage 1: products ----------------
    logic signed [PROD_W-1:0] prod [NUM_TAPS];
    logic                     s1_vld, s1_border;
    logic [DATA_W-1:0]        s1_bval;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_border <= 1'b0;
            s1_bval   <= '0;
            for (int i = 0; i < NUM_TAPS; i++) prod[i] <= '0;
        end else begin
            s1_vld <= launch;
            if (launch) begin
                s1_border <= border_c;
                s1_bval   <= win_nxt[1][1][DATA_W] ? '0
                                                   : win_nxt[1][1][DATA_W-1:0];
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        prod[r*3+c] <=
                            PROD_W'($signed({1'b0, win_nxt[r][c][DATA_W-1:0]}))
                          * PROD_W'(coeff[r*3+c]);
                    end
                end
            end
        end
    end

    // ---------------- stage 2: adder tree ----------------
    logic signed [ACC_W-1:0] acc, s2_sum;
    logic                    s2_vld, s2_border;
    logic [DATA_W-1:0]       s2_bval;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_TAPS; i++) acc = acc + ACC_W'(prod[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld    <= 1'b0;
            s2_border <= 1'b0;
            s2_bval   <= '0;
            s2_sum    <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_border <= s1_border;
                s2_bval   <= s1_bval;
                s2_sum    <= acc;
            end
        end
    end

    // ---------------- stage 3: shift / saturate ----------------
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       sat, dout_q;
    logic                    dwr_q;

    always_comb begin
        shifted = s2_sum >>> SHIFT;
        if (shifted[ACC_W-1])                  sat = '0;
        else if (|shifted[ACC_W-2:DATA_W])     sat = '1;
        else                                   sat = shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwr_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            dwr_q <= s2_vld;
            if (s2_vld) dout_q <= s2_border ? s2_bval : sat;
        end
    end

    assign bus.data_o     = dout_q;
    assign bus.data_write = dwr_q;

endmodule

// File: tb/tb_conv_filter_param_module.sv
// Scoreboard bench for conv_filter_param_module (4x4 frame, SHIFT=3).
// Stimulus pushes expected pixels with due cycles; a monitor pops on data_write.
module tb_conv_filter_param_module;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;
    localparam int SH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_filter_param_module_if #(.DATA_W(8), .COEFF_W(8)) bus ();

    conv_filter_param_module #(
        .DATA_W(8), .COEFF_W(8), .IMG_W(W), .IMG_H(H), .SHIFT(SH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   frame [NP];
    bit   mode  [NP];
    int   kern  [9];
    int   expv  [NP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                      name, act, req, cyc);
    endtask

    // Direct 2-D convolution of the frame as the reference.
    function automatic int ref_out(input int r, input int c);
        int s;
        s = 0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1)
            return mode[r*W+c] ? 0 : frame[r*W+c];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += kern[(dr+1)*3 + dc + 1] * frame[(r+dr)*W + c + dc];
        s = s >>> SH;
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.data_write === 1'b1) begin
                out_cnt++;
                chk("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_o", int'(bus.data_o), e.val);
                    chk("write_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic load_kern();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.coeff_load = 1'b1;
            bus.coeff_in   = 8'(kern[i]);
            if (i == 1) chk("coeff_ready_mid", int'(bus.coeff_ready), 0);
        end
        @(negedge clk);
        bus.coeff_load = 1'b0;
        chk("coeff_ready", int'(bus.coeff_ready), 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic run_frame(input int npix, input bit gap,
                             input bit inj, input bit extra);
        int start;
        int bc;
        start = out_cnt;
        bc = 0;
        for (int i = 0; i < NP; i++) expv[i] = ref_out(i / W, i % W);
        for (int n = 0; n < npix; n++) begin
            @(negedge clk);
            bus.coeff_load  = 1'b0;
            bus.data_load   = 1'b1;
            bus.data_i      = 8'(frame[n]);
            bus.border_mode = mode[n];
            if (n >= W + 1) sb.push_back('{expv[n-W-1], cyc + 3});
            if (n == NP - 1)
                for (int k = 1; k <= W + 1; k++)
                    sb.push_back('{expv[NP-1-(W+1)+k], cyc + k + 3});
            if (gap && n != npix - 1) begin
                @(negedge clk);
                bus.data_load  = 1'b0;
                bus.coeff_load = inj;
                bus.coeff_in   = 8'sd50;
            end
        end
        if (npix == NP) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                bus.coeff_load = 1'b0;
                bus.data_load  = extra && (k < 3);
                bus.data_i     = 8'd99;
                if (bus.busy) bc++;
                else break;
            end
            bus.data_load = 1'b0;
            chk("busy_cycles", bc, W + 1);
            wait_drain();
            chk("frame_outputs", out_cnt - start, NP);
        end
    endtask

    task automatic set_kern_ident();
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 8 : 0;
    endtask

    initial begin : stim
        int snap;
        bus.coeff_load  = 1'b0;
        bus.coeff_in    = '0;
        bus.data_load   = 1'b0;
        bus.data_i      = '0;
        bus.border_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_o", int'(bus.data_o), 0);
        chk("rst_data_write", int'(bus.data_write), 0);
        chk("rst_coeff_ready", int'(bus.coeff_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;

        // Pixels before any kernel: dropped.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.data_load = 1'b1;
            bus.data_i    = 8'(k + 7);
        end
        @(negedge clk);
        bus.data_load = 1'b0;
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_coeff_ready", int'(bus.coeff_ready), 0);

        // Identity (8 >>> 3): outputs 1..16, data_load during flush.
        set_kern_ident();
        load_kern();
        for (int i = 0; i < NP; i++) begin frame[i] = i + 1; mode[i] = 0; end
        run_frame(NP, 0, 0, 1);

        // Box kernel, constant 16: interior 18, border centre / zero.
        for (int i = 0; i < 9; i++) kern[i] = 1;
        load_kern();
        for (int i = 0; i < NP; i++) begin frame[i] = 16; mode[i] = 0; end
        run_frame(NP, 0, 0, 0);
        for (int i = 0; i < NP; i++) mode[i] = 1;
        run_frame(NP, 0, 0, 0);

        // Asymmetric kernel, gapped beats, coeff_load during stream ignored.
        for (int i = 0; i < 9; i++) kern[i] = i + 1;
        load_kern();
        for (int i = 0; i < NP; i++) begin frame[i] = i + 1; mode[i] = i[0]; end
        run_frame(NP, 1, 1, 0);

        // Saturation high and low.
        for (int i = 0; i < 9; i++) kern[i] = 127;
        load_kern();
        for (int i = 0; i < NP; i++) begin frame[i] = 255; mode[i] = 0; end
        run_frame(NP, 0, 0, 0);
        for (int i = 0; i < 9; i++) kern[i] = -1;
        load_kern();
        for (int i = 0; i < NP; i++) mode[i] = (i >= 8);
        run_frame(NP, 0, 0, 0);

        // Reset after pixel 8.
        set_kern_ident();
        load_kern();
        for (int i = 0; i < NP; i++) begin frame[i] = i + 1; mode[i] = 0; end
        run_frame(8, 0, 0, 0);
        @(negedge clk);
        bus.data_load = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        snap = out_cnt;
        chk("mid_rst_coeff_ready", int'(bus.coeff_ready), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_data_o", int'(bus.data_o), 0);
        chk("mid_rst_data_write", int'(bus.data_write), 0);
        repeat (10) @(negedge clk);
        #1;
        chk("writes_after_rst", out_cnt - snap, 0);

        load_kern();
        run_frame(NP, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_filter_param_module.md
CONV_FILTER_PARAM_MODULE -- requirements
Module: conv_filter_param_module

Interface
REQ-001 Parameter DATA_W, default 8: unsigned pixel width in bits.
REQ-002 Parameter COEFF_W, default 8: signed two's-complement coefficient width in bits.
REQ-003 Parameter IMG_W, default 64: pixels per line, minimum 4.
REQ-004 Parameter IMG_H, default 64: lines per frame, minimum 3.
REQ-005 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulated sum.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 coeff_load  input  1  coefficient write strobe.
REQ-009 coeff_in  input  COEFF_W  coefficient value, raster order k0 (top-left) to k8 (bottom-right).
REQ-010 data_load  input  1  pixel write strobe.
REQ-011 data_i  input  DATA_W  pixel value, raster order.
REQ-012 border_mode  input  1  0 = border outputs equal the centre pixel; 1 = border outputs are 0; sampled with each centre pixel.
REQ-013 data_o  output  DATA_W  filtered pixel.
REQ-014 data_write  output  1  data_o valid, one-cycle pulse per output pixel.
REQ-015 coeff_ready  output  1  all 9 coefficients loaded.
REQ-016 busy  output  1  high in FLUSH state.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, READY, STREAM and FLUSH.
REQ-018 In IDLE, LOAD or READY, coeff_load SHALL write coeff_in to index idx, increment idx and enter LOAD; the 9th write SHALL enter READY with idx=0.
REQ-019 A coeff_load in READY SHALL restart loading at index 0 and deassert coeff_ready until the 9th write completes.
REQ-020 In STREAM and FLUSH, coeff_load SHALL be ignored.
REQ-021 data_load in IDLE or LOAD SHALL be ignored, with no counter or buffer change.
REQ-022 data_load in READY SHALL accept the pixel as frame pixel 0 and enter STREAM.
REQ-023 In STREAM, each data_load SHALL accept one pixel, advancing the column counter (0..IMG_W-1, wrapping) and the row counter (0..IMG_H-1).
REQ-024 Accepting pixel IMG_W*IMG_H-1 SHALL enter FLUSH.
REQ-025 In FLUSH, the block SHALL generate IMG_W+1 internal beats on consecutive cycles, each shifting in pixel value 0, then enter READY with all counters cleared.
REQ-026 In FLUSH, data_load SHALL be ignored.
REQ-027 Each beat (accepted pixel or flush beat) with beat index n >= IMG_W+1 SHALL launch one output for centre pixel n-(IMG_W+1).
REQ-028 Outputs SHALL be produced in raster order, exactly IMG_W*IMG_H per frame.
REQ-029 The 3x3 window SHALL be formed from two line buffers of IMG_W entries plus window registers.
REQ-030 An output SHALL be a border output when its centre row is 0 or IMG_H-1, or its centre column is 0 or IMG_W-1.
REQ-031 Window taps outside the frame SHALL never contribute to an output; border outputs SHALL follow REQ-012.
REQ-032 Interior outputs SHALL be computed as sum of k_i * pixel_i, with pixels zero-extended to signed and the accumulator DATA_W+COEFF_W+5 bits wide.
REQ-033 The sum SHALL be arithmetically shifted right by SHIFT, then saturated to the range 0..2^DATA_W-1.
REQ-034 The datapath SHALL have 3 register stages: products, adder tree, shift/saturate.
REQ-035 data_write SHALL pulse exactly 3 cycles after the launching beat, with data_o valid in that same cycle.
REQ-036 data_o SHALL hold its last value while data_write is low.
REQ-037 Non-consecutive data_load beats SHALL be accepted; output timing is relative to each launching beat.

Reset
REQ-038 rst SHALL force state IDLE, all counters and idx to 0, and coefficients, line buffers, window and pipeline to 0.
REQ-039 rst SHALL force data_o=0, data_write=0, coeff_ready=0, busy=0 in the next cycle.
REQ-040 rst asserted mid-frame SHALL discard all in-flight outputs: no data_write pulse follows reset.

Structure
REQ-041 Package conv_pkg SHALL hold the FSM state enum, the constant NUM_TAPS=9, and an accumulator-width function.
REQ-042 The line buffer SHALL be one sub-module, conv_line_buffer_module, parametrised by DATA_W and IMG_W, instantiated twice.

Verification
REQ-043 IMG_W=4, IMG_H=4: load kernel with k4=1 and all others 0, SHIFT=0, border_mode=0, pixels 1..16 -> outputs 1..16 in order; first data_write 3 cycles after pixel 6 is accepted.
REQ-044 All coefficients 1, SHIFT=3, constant pixel 16 -> interior outputs 18; with border_mode=1, the 12 border outputs are 0 and the 4 interior outputs are 18.
REQ-045 Saturation: pixels 255 with all coefficients 127 -> interior outputs 255; all coefficients -1 -> interior outputs 0.
REQ-046 data_load before coefficients load, and coeff_load during STREAM -> both ignored; a full frame then yields exactly 16 outputs using the original kernel.
REQ-047 rst after pixel 8 of a frame -> no further data_write and coeff_ready=0; a subsequent reload plus frame gives correct outputs.
REQ-048 After the last pixel, busy=1 for exactly IMG_W+1=5 cycles, and the final output appears 3 cycles after the last flush beat.
